// File: rtl/color_sensor_ctrl.sv
// Colour-sensor transaction sequencer. It writes the register configuration
// table through the I2C byte engine. It then polls the eight channel bytes
// periodically and publishes them. NACKs and timeouts are retried, and
// repeated failure ends in a sticky error.
module color_sensor_ctrl #(
  parameter logic [6:0]  SLAVE_ID    = 7'h53,
  parameter int unsigned WAIT_CYCLES = 1_000_000,
  parameter int unsigned POLL_CYCLES = 5_000_000,
  parameter int unsigned TO_CYCLES   = 20_000,
  parameter int unsigned MAX_RETRY   = 3,
  parameter logic [7:0]  DATA_REG    = 8'h14
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  output logic        tx_req,
  output logic        tx_rw,
  output logic [6:0]  tx_dev,
  output logic [7:0]  tx_reg,
  output logic [7:0]  tx_wdata,
  input  logic        tx_done,
  input  logic        tx_nack,
  input  logic [7:0]  tx_rdata,
  output logic [15:0] clear_ch,
  output logic [15:0] red_ch,
  output logic [15:0] green_ch,
  output logic [15:0] blue_ch,
  output logic        data_vld,
  output logic        cfg_done,
  output logic        err
);

  localparam int unsigned RetryW = (MAX_RETRY > 1) ? $clog2(MAX_RETRY) : 1;
  localparam logic [RetryW-1:0] RetryLast = RetryW'(MAX_RETRY - 1);
  localparam logic [31:0] WaitLast = 32'(WAIT_CYCLES);
  localparam logic [31:0] PollLast = 32'(POLL_CYCLES);
  localparam logic [31:0] ToLast   = 32'(TO_CYCLES - 1);
  localparam logic [1:0]  CfgLast  = 2'd2;

  typedef enum logic [2:0] {
    StWait, StCfgReq, StCfgWait, StIdle, StRdReq, StRdWait, StUpdate, StError
  } state_e;

  state_e state_q, state_d;
  logic [31:0] timer_q, timer_d;
  logic [1:0]  cfg_idx_q, cfg_idx_d;
  logic [2:0]  byte_idx_q, byte_idx_d;
  logic [RetryW-1:0] retry_q, retry_d;
  logic        tx_rw_q, tx_rw_d;
  logic [7:0]  tx_reg_q, tx_reg_d;
  logic [7:0]  tx_wdata_q, tx_wdata_d;
  logic        cfg_done_q, cfg_done_d;
  logic [7:0]  shadow_q [7];
  logic [15:0] clear_q, red_q, green_q, blue_q;
  logic        store, publish, fail;

  // Configuration table as {reg, data}.
  function automatic logic [15:0] cfg_entry(input logic [1:0] idx);
    case (idx)
      2'd0:    cfg_entry = 16'h00_06;
      2'd1:    cfg_entry = 16'h01_F6;
      default: cfg_entry = 16'h0F_01;
    endcase
  endfunction

  // Next-state, transaction setup and retry decisions.
  always_comb begin
    state_d    = state_q;
    cfg_idx_d  = cfg_idx_q;
    byte_idx_d = byte_idx_q;
    retry_d    = retry_q;
    tx_rw_d    = tx_rw_q;
    tx_reg_d   = tx_reg_q;
    tx_wdata_d = tx_wdata_q;
    cfg_done_d = cfg_done_q;
    store      = 1'b0;
    publish    = 1'b0;
    fail       = 1'b0;
    unique case (state_q)
      StWait: begin
        if (timer_q == WaitLast) begin
          state_d                = StCfgReq;
          cfg_idx_d              = 2'd0;
          tx_rw_d                = 1'b0;
          {tx_reg_d, tx_wdata_d} = cfg_entry(2'd0);
        end
      end
      StCfgReq: state_d = StCfgWait;
      StCfgWait: begin
        if (tx_done && !tx_nack) begin
          retry_d = '0;
          if (cfg_idx_q == CfgLast) begin
            state_d    = StIdle;
            cfg_done_d = 1'b1;
          end else begin
            state_d                = StCfgReq;
            cfg_idx_d              = cfg_idx_q + 2'd1;
            {tx_reg_d, tx_wdata_d} = cfg_entry(cfg_idx_q + 2'd1);
          end
        end else if (tx_done || timer_q == ToLast) begin
          fail = 1'b1;
        end
      end
      StIdle: begin
        if (enable && timer_q == PollLast) begin
          state_d    = StRdReq;
          byte_idx_d = 3'd0;
          tx_rw_d    = 1'b1;
          tx_reg_d   = DATA_REG;
        end
      end
      StRdReq: state_d = StRdWait;
      StRdWait: begin
        if (tx_done && !tx_nack) begin
          retry_d = '0;
          if (byte_idx_q == 3'd7) begin
            state_d    = StUpdate;
            publish    = 1'b1;
            byte_idx_d = 3'd0;
          end else begin
            state_d    = StRdReq;
            store      = 1'b1;
            byte_idx_d = byte_idx_q + 3'd1;
            tx_reg_d   = DATA_REG + {5'd0, byte_idx_q + 3'd1};
          end
        end else if (tx_done || timer_q == ToLast) begin
          fail = 1'b1;
        end
      end
      StUpdate: state_d = StIdle;
      StError:  state_d = StError;
      default:  state_d = StError;
    endcase
    // A retry reissues the same request; the tx_* registers are left untouched.
    if (fail) begin
      if (retry_q == RetryLast) begin
        state_d = StError;
      end else begin
        retry_d = retry_q + 1'b1;
        state_d = (state_q == StCfgWait) ? StCfgReq : StRdReq;
      end
    end
  end

  // Shared timer: power-up wait, poll interval and transaction timeout.
  // It clears on every state change.
  always_comb begin
    timer_d = '0;
    if (state_d == state_q) begin
      unique case (state_q)
        StWait, StCfgWait, StRdWait: timer_d = timer_q + 32'd1;
        StIdle:  timer_d = enable ? timer_q + 32'd1 : 32'd0;
        default: timer_d = '0;
      endcase
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StWait;
      timer_q    <= '0;
      cfg_idx_q  <= '0;
      byte_idx_q <= '0;
      retry_q    <= '0;
      tx_rw_q    <= 1'b0;
      tx_reg_q   <= '0;
      tx_wdata_q <= '0;
      cfg_done_q <= 1'b0;
      clear_q    <= '0;
      red_q      <= '0;
      green_q    <= '0;
      blue_q     <= '0;
      for (int i = 0; i < 7; i++) shadow_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      cfg_idx_q  <= cfg_idx_d;
      byte_idx_q <= byte_idx_d;
      retry_q    <= retry_d;
      tx_rw_q    <= tx_rw_d;
      tx_reg_q   <= tx_reg_d;
      tx_wdata_q <= tx_wdata_d;
      cfg_done_q <= cfg_done_d;
      if (store) shadow_q[byte_idx_q] <= tx_rdata;
      // Byte 7 arrives with the final done, so it bypasses the shadow.
      if (publish) begin
        clear_q <= {shadow_q[1], shadow_q[0]};
        red_q   <= {shadow_q[3], shadow_q[2]};
        green_q <= {shadow_q[5], shadow_q[4]};
        blue_q  <= {tx_rdata, shadow_q[6]};
      end
    end
  end

  // Output decode from registered state.
  always_comb begin
    tx_req   = (state_q == StCfgReq) || (state_q == StRdReq);
    tx_rw    = tx_rw_q;
    tx_dev   = SLAVE_ID;
    tx_reg   = tx_reg_q;
    tx_wdata = tx_wdata_q;
    clear_ch = clear_q;
    red_ch   = red_q;
    green_ch = green_q;
    blue_ch  = blue_q;
    data_vld = (state_q == StUpdate);
    cfg_done = cfg_done_q;
    err      = (state_q == StError);
  end

endmodule

// File: tb/tb_color_sensor_ctrl.sv
// Self-checking bench for color_sensor_ctrl with a behavioural I2C engine model
// that answers each request 20 cycles later (ACK, NACK or no answer).
module tb_color_sensor_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        enable;
  logic        tx_req, tx_rw;
  logic [6:0]  tx_dev;
  logic [7:0]  tx_reg, tx_wdata;
  logic        tx_done, tx_nack;
  logic [7:0]  tx_rdata;
  logic [15:0] clear_ch, red_ch, green_ch, blue_ch;
  logic        data_vld, cfg_done, err;

  color_sensor_ctrl #(
    .SLAVE_ID   (7'h53),
    .WAIT_CYCLES(10),
    .POLL_CYCLES(50),
    .TO_CYCLES  (100),
    .MAX_RETRY  (3),
    .DATA_REG   (8'h14)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (enable),
    .tx_req  (tx_req),
    .tx_rw   (tx_rw),
    .tx_dev  (tx_dev),
    .tx_reg  (tx_reg),
    .tx_wdata(tx_wdata),
    .tx_done (tx_done),
    .tx_nack (tx_nack),
    .tx_rdata(tx_rdata),
    .clear_ch(clear_ch),
    .red_ch  (red_ch),
    .green_ch(green_ch),
    .blue_ch (blue_ch),
    .data_vld(data_vld),
    .cfg_done(cfg_done),
    .err     (err)
  );

  typedef struct {
    int         cyc;
    logic       rw;
    logic [7:0] rg;
    logic [7:0] wd;
  } txn_t;

  txn_t log_q[$];
  txn_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = -1;
  int   vld_cnt = 0;
  int   vld_base;
  int   policy [64];   // per transaction: 0 ACK, 1 NACK, 2 never answer
  logic [7:0] rd_xor;
  logic [7:0] rd_bytes [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};

  // Cycle k is the period following the k-th edge after reset release.
  always @(posedge clk) cyc <= rst_n ? cyc + 1 : -1;

  always @(negedge clk) if (rst_n && data_vld) vld_cnt <= vld_cnt + 1;

  // I2C engine model.
  initial begin : engine
    int         cnt;
    int         pol;
    int         txn;
    logic       busy;
    logic [7:0] roff;
    txn_t       t;
    tx_done = 1'b0;
    tx_nack = 1'b0;
    tx_rdata = 8'h00;
    busy = 1'b0;
    cnt = 0;
    pol = 0;
    txn = 0;
    roff = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      tx_done = 1'b0;
      tx_nack = 1'b0;
      if (!rst_n) begin
        busy = 1'b0;
        txn  = 0;
      end else begin
        if (busy) begin
          cnt--;
          if (cnt == 0) begin
            busy = 1'b0;
            if (pol != 2) begin
              tx_done  = 1'b1;
              tx_nack  = (pol == 1);
              tx_rdata = rd_bytes[roff[2:0]] ^ rd_xor;
            end
          end
        end
        if (tx_req) begin
          t.cyc = cyc;
          t.rw  = tx_rw;
          t.rg  = tx_reg;
          t.wd  = tx_wdata;
          log_q.push_back(t);
          roff = tx_reg - 8'h14;
          pol  = (txn < 64) ? policy[txn] : 0;
          txn++;
          busy = 1'b1;
          cnt  = 20;
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    int g = 0;
    while (cyc < n && g < 5000) begin
      @(posedge clk);
      #1;
      g++;
    end
  endtask

  task automatic add_exp(input int c, input logic rw, input logic [7:0] rg, input logic [7:0] wd);
    txn_t t;
    t.cyc = c;
    t.rw  = rw;
    t.rg  = rg;
    t.wd  = wd;
    exp_q.push_back(t);
  endtask

  // Table-driven comparison of observed requests against the expected list.
  task automatic check_log(input string tag);
    logic [63:0] a, e;
    check($sformatf("%s txn count", tag), 64'(log_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      a = {32'(log_q[i].cyc), 7'd0, log_q[i].rw, log_q[i].rg, log_q[i].wd};
      e = {32'(exp_q[i].cyc), 7'd0, exp_q[i].rw, exp_q[i].rg, exp_q[i].wd};
      check($sformatf("%s txn %0d {cyc,rw,reg,wdata}", tag, i), a, e);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " ctrl outputs"},
          64'({tx_req, tx_rw, tx_reg, tx_wdata, data_vld, cfg_done, err}), 64'd0);
    check({tag, " channels"}, {clear_ch, red_ch, green_ch, blue_ch}, 64'd0);
    check({tag, " tx_dev"}, 64'(tx_dev), 64'h53);
  endtask

  task automatic start_run();
    log_q.delete();
    exp_q.delete();
    vld_base = vld_cnt;
    #0 rst_n = 1'b1;
  endtask

  initial begin : main
    rst_n  = 1'b0;
    enable = 1'b0;
    rd_xor = 8'h00;
    for (int i = 0; i < 64; i++) policy[i] = 0;

    // ---- Run 1: power-up, read burst, error on read byte 3 ----
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset1");
    for (int i = 14; i <= 16; i++) policy[i] = 1;
    start_run();
    wait_cyc(9);
    check("r1 no req in wait", 64'(tx_req), 64'd0);
    wait_cyc(10);
    check("r1 first req", 64'({tx_req, tx_rw, tx_reg, tx_wdata}), {47'd0, 1'b1, 1'b0, 8'h00, 8'h06});
    wait_cyc(72);
    check("r1 cfg_done before", 64'(cfg_done), 64'd0);
    wait_cyc(73);
    check("r1 cfg_done after", 64'(cfg_done), 64'd1);
    wait_cyc(299);
    check("r1 no poll while disabled", 64'(log_q.size()), 64'd3);
    wait_cyc(300);
    enable = 1'b1;
    wait_cyc(400);
    enable = 1'b0;  // mid-burst; burst must still complete
    wait_cyc(518);
    check("r1 vld before update", 64'(data_vld), 64'd0);
    check("r1 channels before update", {clear_ch, red_ch, green_ch, blue_ch}, 64'd0);
    wait_cyc(519);
    check("r1 vld at update", 64'(data_vld), 64'd1);
    check("r1 channels", {clear_ch, red_ch, green_ch, blue_ch}, 64'h2211_4433_6655_8877);
    wait_cyc(520);
    check("r1 vld one cycle", 64'(data_vld), 64'd0);
    wait_cyc(530);
    enable = 1'b1;
    rd_xor = 8'hFF;
    wait_cyc(706);
    check("r1 err before", 64'(err), 64'd0);
    wait_cyc(707);
    check("r1 err after", 64'(err), 64'd1);
    wait_cyc(900);
    check("r1 vld count", 64'(vld_cnt - vld_base), 64'd1);
    check("r1 channels kept", {clear_ch, red_ch, green_ch, blue_ch}, 64'h2211_4433_6655_8877);
    check("r1 err sticky", 64'(err), 64'd1);
    add_exp(10, 1'b0, 8'h00, 8'h06);
    add_exp(31, 1'b0, 8'h01, 8'hF6);
    add_exp(52, 1'b0, 8'h0F, 8'h01);
    for (int k = 0; k < 8; k++) add_exp(351 + 21 * k, 1'b1, 8'h14 + 8'(k), 8'h01);
    for (int k = 0; k < 4; k++) add_exp(581 + 21 * k, 1'b1, 8'h14 + 8'(k), 8'h01);
    add_exp(665, 1'b1, 8'h17, 8'h01);
    add_exp(686, 1'b1, 8'h17, 8'h01);
    check_log("r1");

    // ---- Run 2: NACK retry in configuration, burst, reset during byte 5 ----
    rst_n  = 1'b0;
    enable = 1'b0;
    rd_xor = 8'h00;
    for (int i = 0; i < 64; i++) policy[i] = 0;
    policy[1] = 1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset2");
    start_run();
    wait_cyc(93);
    check("r2 cfg_done before", 64'(cfg_done), 64'd0);
    wait_cyc(94);
    check("r2 cfg_done after", 64'(cfg_done), 64'd1);
    wait_cyc(150);
    check("r2 no err after nack", 64'(err), 64'd0);
    wait_cyc(200);
    enable = 1'b1;
    wait_cyc(419);
    check("r2 vld", 64'(data_vld), 64'd1);
    check("r2 channels", {clear_ch, red_ch, green_ch, blue_ch}, 64'h2211_4433_6655_8877);
    wait_cyc(580);
    add_exp(10, 1'b0, 8'h00, 8'h06);
    add_exp(31, 1'b0, 8'h01, 8'hF6);
    add_exp(52, 1'b0, 8'h01, 8'hF6);
    add_exp(73, 1'b0, 8'h0F, 8'h01);
    for (int k = 0; k < 8; k++) add_exp(251 + 21 * k, 1'b1, 8'h14 + 8'(k), 8'h01);
    for (int k = 0; k < 6; k++) add_exp(471 + 21 * k, 1'b1, 8'h14 + 8'(k), 8'h01);
    check_log("r2");
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs("midburst reset");

    // ---- Run 3: restart after reset, then three timeouts ----
    enable = 1'b0;
    for (int i = 0; i < 64; i++) policy[i] = 0;
    for (int i = 0; i < 3; i++) policy[i] = 2;
    repeat (2) @(posedge clk);
    #1;
    start_run();
    wait_cyc(10);
    check("r3 restart req", 64'({tx_req, tx_rw, tx_reg, tx_wdata}), {47'd0, 1'b1, 1'b0, 8'h00, 8'h06});
    wait_cyc(312);
    check("r3 err before", 64'(err), 64'd0);
    wait_cyc(313);
    check("r3 err after", 64'(err), 64'd1);
    wait_cyc(500);
    check("r3 cfg_done", 64'(cfg_done), 64'd0);
    add_exp(10, 1'b0, 8'h00, 8'h06);
    add_exp(111, 1'b0, 8'h00, 8'h06);
    add_exp(212, 1'b0, 8'h00, 8'h06);
    check_log("r3");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
